// File: rtl/iso7816_tpdu_sequencer_pkg.sv
// Shared definitions for the ISO7816 TPDU script sequencer: opcodes, FSM states,
// failure codes and master statusOut bit positions.
package iso7816_tpdu_sequencer_pkg;

    // Script entry opcode, bits [9:8] of an entry
    typedef enum logic [1:0] {
        OpEnd    = 2'b00,
        OpSend   = 2'b01,
        OpExpect = 2'b10,
        OpSkip   = 2'b11
    } opcodeT;

    typedef enum logic [3:0] {
        StIdle,
        StActivate,
        StWaitAct,
        StFetch,
        StDecode,
        StSend,
        StSendAck,
        StRxWait,
        StRxTake,
        StEnd,
        StDone,
        StFail
    } stateT;

    // failCode values
    localparam logic [2:0] FcNone     = 3'd0;
    localparam logic [2:0] FcMismatch = 3'd1;
    localparam logic [2:0] FcTimeout  = 3'd2;
    localparam logic [2:0] FcOverrun  = 3'd3;
    localparam logic [2:0] FcFrame    = 3'd4;
    localparam logic [2:0] FcWrap     = 3'd5;

    // statusOut bit indices
    localparam int unsigned BitBufferFull = 0;
    localparam int unsigned BitFrameErr   = 1;
    localparam int unsigned BitOverrunErr = 2;
    localparam int unsigned BitIsTx       = 3;
    localparam int unsigned BitRxStartBit = 4;
    localparam int unsigned BitRxRun      = 5;
    localparam int unsigned BitTxPending  = 6;
    localparam int unsigned BitTxRun      = 7;

    // A run is in progress in every state except the idle and terminal ones
    function automatic logic stateBusy(input stateT s);
        return !(s inside {StIdle, StDone, StFail});
    endfunction

endpackage

// File: rtl/iso7816_script_ram.sv
// Script storage: DEPTH x WIDTH simple dual-port RAM, synchronous read with
// one cycle of latency. A same-cycle write and read of one address returns
// the old contents.
module iso7816_script_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 10,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/iso7816_tpdu_sequencer.sv
// Script engine driving one Iso7816_3_Master byte port: activates the card,
// then walks SEND / EXPECT / SKIP / END entries, with per-wait timeout and
// first-error bookkeeping.
module iso7816_tpdu_sequencer
    import iso7816_tpdu_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned TIMEOUT_W = 24,
    parameter int unsigned ERRCNT_W  = 8,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 scriptWe,
    input  logic [AW-1:0]        scriptAddr,
    input  logic [9:0]           scriptData,
    input  logic                 start,
    input  logic                 stopOnError,
    input  logic [TIMEOUT_W-1:0] timeoutCycles,
    output logic                 startActivation,
    input  logic                 isActivated,
    input  logic                 tsReceived,
    output logic [7:0]           dataIn,
    output logic                 nWeDataIn,
    input  logic [7:0]           dataOut,
    output logic                 nCsDataOut,
    input  logic [7:0]           statusOut,
    output logic                 nCsStatusOut,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERRCNT_W-1:0]  errCnt,
    output logic [AW-1:0]        failIndex,
    output logic [2:0]           failCode,
    output logic [7:0]           lastRx
);

    localparam logic [AW-1:0] PcLast = AW'(DEPTH - 1);

    stateT                stateQ, stateD;
    logic [AW-1:0]        pcQ, pcD;
    logic [TIMEOUT_W-1:0] tmrQ, tmrD;
    logic [ERRCNT_W-1:0]  errCntQ, errCntD;
    logic [AW-1:0]        failIndexQ, failIndexD;
    logic [2:0]           failCodeQ, failCodeD;
    logic [7:0]           lastRxQ, lastRxD;
    logic [7:0]           dataInQ, dataInD;
    logic [7:0]           curByteQ, curByteD;
    opcodeT               curOpQ, curOpD;

    logic [9:0] ramRdData;
    logic       ramWe;
    logic       ramRe;
    opcodeT     rdOp;

    logic       tmrExpired;
    logic       logErr;
    logic [2:0] errCode;
    logic       incErr;
    logic       doAdvance;

    // isTx / rxRun / rxStartBit are not needed by the sequencer
    logic unusedStatus;
    assign unusedStatus = ^{statusOut[BitIsTx], statusOut[BitRxStartBit], statusOut[BitRxRun]};

    // The script is frozen while a run is active
    assign ramWe = scriptWe && !stateBusy(stateQ);
    assign rdOp  = opcodeT'(ramRdData[9:8]);

    iso7816_script_ram #(
        .DEPTH (DEPTH),
        .WIDTH (10),
        .AW    (AW)
    ) uScriptRam (
        .clk   (clk),
        .we    (ramWe),
        .waddr (scriptAddr),
        .wdata (scriptData),
        .re    (ramRe),
        .raddr (pcQ),
        .rdata (ramRdData)
    );

    // Fires on the timeoutCycles-th cycle spent in a wait state
    assign tmrExpired = (timeoutCycles != '0) &&
                        (tmrQ == timeoutCycles - TIMEOUT_W'(1));

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nReset) begin
            stateQ     <= StIdle;
            pcQ        <= '0;
            tmrQ       <= '0;
            errCntQ    <= '0;
            failIndexQ <= '0;
            failCodeQ  <= FcNone;
            lastRxQ    <= '0;
            dataInQ    <= '0;
            curByteQ   <= '0;
            curOpQ     <= OpEnd;
        end else begin
            stateQ     <= stateD;
            pcQ        <= pcD;
            tmrQ       <= tmrD;
            errCntQ    <= errCntD;
            failIndexQ <= failIndexD;
            failCodeQ  <= failCodeD;
            lastRxQ    <= lastRxD;
            dataInQ    <= dataInD;
            curByteQ   <= curByteD;
            curOpQ     <= curOpD;
        end
    end

    // Next-state, timeout and error bookkeeping
    always_comb begin
        stateD     = stateQ;
        pcD        = pcQ;
        tmrD       = tmrQ;
        errCntD    = errCntQ;
        failIndexD = failIndexQ;
        failCodeD  = failCodeQ;
        lastRxD    = lastRxQ;
        dataInD    = dataInQ;
        curByteD   = curByteQ;
        curOpD     = curOpQ;
        ramRe      = 1'b0;
        logErr     = 1'b0;
        errCode    = FcNone;
        incErr     = 1'b0;
        doAdvance  = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD     = StActivate;
                    pcD        = '0;
                    tmrD       = '0;
                    errCntD    = '0;
                    failIndexD = '0;
                    failCodeD  = FcNone;
                    lastRxD    = '0;
                end
            end
            StActivate: begin
                if (isActivated) begin
                    stateD = StWaitAct;
                    tmrD   = '0;
                end else if (tmrExpired) begin
                    stateD  = StFail;
                    logErr  = 1'b1;
                    errCode = FcTimeout;
                end else begin
                    tmrD = tmrQ + 1'b1;
                end
            end
            StWaitAct: begin
                if (tsReceived) begin
                    stateD = StFetch;
                end else if (tmrExpired) begin
                    stateD  = StFail;
                    logErr  = 1'b1;
                    errCode = FcTimeout;
                end else begin
                    tmrD = tmrQ + 1'b1;
                end
            end
            StFetch: begin
                ramRe  = 1'b1;
                stateD = StDecode;
            end
            StDecode: begin
                curOpD   = rdOp;
                curByteD = ramRdData[7:0];
                tmrD     = '0;
                unique case (rdOp)
                    OpEnd:           stateD = StEnd;
                    OpSend:          stateD = StSend;
                    OpExpect, OpSkip: stateD = StRxWait;
                    default:         stateD = StEnd;
                endcase
            end
            StSend: begin
                if (!statusOut[BitTxPending]) begin
                    dataInD = curByteQ;
                    stateD  = StSendAck;
                end else if (tmrExpired) begin
                    stateD  = StFail;
                    logErr  = 1'b1;
                    errCode = FcTimeout;
                end else begin
                    tmrD = tmrQ + 1'b1;
                end
            end
            StSendAck: begin
                doAdvance = 1'b1;
            end
            StRxWait: begin
                if (statusOut[BitBufferFull]) begin
                    stateD = StRxTake;
                end else if (tmrExpired) begin
                    stateD  = StFail;
                    logErr  = 1'b1;
                    errCode = FcTimeout;
                end else begin
                    tmrD = tmrQ + 1'b1;
                end
            end
            StRxTake: begin
                lastRxD = dataOut;
                // Line errors end the run whatever stopOnError says
                if (statusOut[BitOverrunErr]) begin
                    stateD  = StFail;
                    logErr  = 1'b1;
                    errCode = FcOverrun;
                    incErr  = 1'b1;
                end else if (statusOut[BitFrameErr]) begin
                    stateD  = StFail;
                    logErr  = 1'b1;
                    errCode = FcFrame;
                    incErr  = 1'b1;
                end else if (curOpQ == OpExpect && dataOut != curByteQ) begin
                    logErr  = 1'b1;
                    errCode = FcMismatch;
                    incErr  = 1'b1;
                    if (stopOnError) begin
                        stateD = StFail;
                    end else begin
                        doAdvance = 1'b1;
                    end
                end else begin
                    doAdvance = 1'b1;
                end
            end
            StEnd: begin
                if (!statusOut[BitTxRun] && !statusOut[BitTxPending]) begin
                    stateD = StDone;
                end
            end
            StDone, StFail: begin
                if (!start) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase

        // Stepping past the last entry without an END is an error; a mismatch
        // in the same cycle keeps precedence as the first error.
        if (doAdvance) begin
            if (pcQ == PcLast) begin
                stateD = StFail;
                if (!logErr) begin
                    logErr  = 1'b1;
                    errCode = FcWrap;
                end
            end else begin
                pcD    = pcQ + 1'b1;
                stateD = StFetch;
            end
        end

        if (logErr && failCodeQ == FcNone) begin
            failCodeD  = errCode;
            failIndexD = pcQ;
        end

        if (incErr && errCntQ != '1) begin
            errCntD = errCntQ + 1'b1;
        end
    end

    // Port strobes decode straight from the registered state
    always_comb begin
        startActivation = (stateQ != StIdle);
        nWeDataIn       = (stateQ != StSendAck);
        nCsDataOut      = (stateQ != StRxTake);
        nCsStatusOut    = 1'b0;
        dataIn          = dataInQ;
        busy            = stateBusy(stateQ);
        done            = (stateQ == StDone) || (stateQ == StFail);
        pass            = (stateQ == StDone) && (errCntQ == '0);
        errCnt          = errCntQ;
        failIndex       = failIndexQ;
        failCode        = failCodeQ;
        lastRx          = lastRxQ;
    end

endmodule

// File: tb/tb_iso7816_tpdu_sequencer.sv
// Directed bench for iso7816_tpdu_sequencer with a behavioural master/card
// model. Transmitted bytes and end-of-run results are scoreboarded.
module tb_iso7816_tpdu_sequencer;
    import iso7816_tpdu_sequencer_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        nReset;
    logic        scriptWe;
    logic [5:0]  scriptAddr;
    logic [9:0]  scriptData;
    logic        start;
    logic        stopOnError;
    logic [23:0] timeoutCycles;
    logic        startActivation;
    logic        isActivated = 1'b0;
    logic        tsReceived = 1'b0;
    logic [7:0]  dataIn;
    logic        nWeDataIn;
    logic [7:0]  dataOut = 8'h00;
    logic        nCsDataOut;
    logic [7:0]  statusOut;
    logic        nCsStatusOut;
    logic        busy, done, pass;
    logic [7:0]  errCnt;
    logic [5:0]  failIndex;
    logic [2:0]  failCode;
    logic [7:0]  lastRx;

    always #5 clk = ~clk;

    iso7816_tpdu_sequencer dut (
        .clk             (clk),
        .nReset          (nReset),
        .scriptWe        (scriptWe),
        .scriptAddr      (scriptAddr),
        .scriptData      (scriptData),
        .start           (start),
        .stopOnError     (stopOnError),
        .timeoutCycles   (timeoutCycles),
        .startActivation (startActivation),
        .isActivated     (isActivated),
        .tsReceived      (tsReceived),
        .dataIn          (dataIn),
        .nWeDataIn       (nWeDataIn),
        .dataOut         (dataOut),
        .nCsDataOut      (nCsDataOut),
        .statusOut       (statusOut),
        .nCsStatusOut    (nCsStatusOut),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .errCnt          (errCnt),
        .failIndex       (failIndex),
        .failCode        (failCode),
        .lastRx          (lastRx)
    );

    // ---------------- master + dummy card model ----------------
    // Card answers the 5-byte header with procedure byte 0C, and the
    // following data byte with status 90 00.
    int         actCnt = 0;
    int         txCount = 0;
    int         txTimer = 0;
    int         rxDelay = 0;
    logic       bufferFull = 1'b0;
    logic       forceFrame = 1'b0;
    logic [7:0] rxQ[$];
    logic [7:0] rxByte;

    assign statusOut = {(txTimer != 0), (txTimer > 3), 3'b000, 1'b0, forceFrame, bufferFull};

    always @(posedge clk) begin
        if (!startActivation) begin
            actCnt      <= 0;
            isActivated <= 1'b0;
            tsReceived  <= 1'b0;
            txCount     <= 0;
            txTimer     <= 0;
            rxDelay     <= 0;
            bufferFull  <= 1'b0;
            rxQ.delete();
        end else begin
            if (actCnt != 15) actCnt <= actCnt + 1;
            isActivated <= (actCnt >= 3);
            tsReceived  <= (actCnt >= 8);
            if (txTimer != 0) txTimer <= txTimer - 1;
            if (rxDelay != 0) rxDelay <= rxDelay - 1;
            if (!nWeDataIn) begin
                txTimer <= 6;
                txCount <= txCount + 1;
                if (txCount == 4) rxQ.push_back(8'h0C);
                if (txCount == 5) begin
                    rxQ.push_back(8'h90);
                    rxQ.push_back(8'h00);
                end
            end
            if (!nCsDataOut) begin
                bufferFull <= 1'b0;
                rxDelay    <= 3;
            end else if (!bufferFull && rxDelay == 0 && txTimer == 0 && rxQ.size() > 0) begin
                rxByte = rxQ.pop_front();
                dataOut    <= rxByte;
                bufferFull <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct packed {
        logic       pass;
        logic [7:0] errCnt;
        logic [2:0] failCode;
        logic [5:0] failIndex;
        logic [7:0] lastRx;
    } resT;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         lastWe = -100;
    int         csCount = 0;
    logic [7:0] txExp[$];
    resT        resQ[$];
    logic [9:0] scriptMdl [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample on the falling edge and score any write strobe
    task automatic step();
        logic [8:0] expB;
        @(negedge clk);
        if (nWeDataIn === 1'b0) begin
            expB = (txExp.size() > 0) ? {1'b0, txExp.pop_front()} : 9'h1FF;
            chk("txByte", {23'd0, 1'b0, dataIn}, {23'd0, expB});
            chk("weGap", 32'((cyc - lastWe) >= 3), 32'd1);
            lastWe = cyc;
        end
        if (nCsDataOut === 1'b0) csCount++;
        cyc++;
    endtask

    task automatic load(input int a, input logic [1:0] op, input logic [7:0] b);
        scriptWe   = 1'b1;
        scriptAddr = a[5:0];
        scriptData = {op, b};
        scriptMdl[a] = {op, b};
        step();
        scriptWe = 1'b0;
    endtask

    task automatic loadBase();
        load(0, OpSend,   8'h00);
        load(1, OpSend,   8'h0C);
        load(2, OpSend,   8'h00);
        load(3, OpSend,   8'h00);
        load(4, OpSend,   8'h01);
        load(5, OpExpect, 8'h0C);
        load(6, OpSend,   8'h55);
        load(7, OpExpect, 8'h90);
        load(8, OpExpect, 8'h00);
        load(9, OpEnd,    8'h00);
    endtask

    // Queue the first n SEND bytes of the script model, in program order
    task automatic pushTx(input int n);
        int k;
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (k < n && scriptMdl[i][9:8] == 2'(OpSend)) begin
                txExp.push_back(scriptMdl[i][7:0]);
                k++;
            end
        end
    endtask

    function automatic resT mkRes(input logic p, input logic [7:0] e, input logic [2:0] fc,
                                  input logic [5:0] fi, input logic [7:0] lr);
        resT r;
        r.pass = p; r.errCnt = e; r.failCode = fc; r.failIndex = fi; r.lastRx = lr;
        return r;
    endfunction

    task automatic chkReset(input string tag);
        chk({tag, ".startAct"}, {31'd0, startActivation}, 32'd0);
        chk({tag, ".nWe"},      {31'd0, nWeDataIn},       32'd1);
        chk({tag, ".nCs"},      {31'd0, nCsDataOut},      32'd1);
        chk({tag, ".nCsSt"},    {31'd0, nCsStatusOut},    32'd0);
        chk({tag, ".dataIn"},   {24'd0, dataIn},          32'd0);
        chk({tag, ".busy"},     {31'd0, busy},            32'd0);
        chk({tag, ".done"},     {31'd0, done},            32'd0);
        chk({tag, ".pass"},     {31'd0, pass},            32'd0);
        chk({tag, ".errCnt"},   {24'd0, errCnt},          32'd0);
        chk({tag, ".failIdx"},  {26'd0, failIndex},       32'd0);
        chk({tag, ".failCode"}, {29'd0, failCode},        32'd0);
        chk({tag, ".lastRx"},   {24'd0, lastRx},          32'd0);
    endtask

    // Run the loaded script, optionally poking the RAM while busy
    task automatic runCheck(input string tag, input resT exp, input int budget,
                            input bit poke, output int tsEl);
        int  n;
        int  tsAt;
        resT r;
        resQ.push_back(exp);
        start = 1'b1;
        n = 0;
        tsAt = -1;
        while (done !== 1'b1 && n < budget) begin
            if (poke && n == 2) begin
                scriptWe   = 1'b1;
                scriptAddr = 6'd9;
                scriptData = {OpSend, 8'hFF};
            end else begin
                scriptWe = 1'b0;
            end
            step();
            n++;
            if (tsAt < 0 && tsReceived === 1'b1) tsAt = n;
        end
        scriptWe = 1'b0;
        tsEl = n - tsAt;
        r = resQ.pop_front();
        chk({tag, ".done"},     {31'd0, done},      32'd1);
        chk({tag, ".busy"},     {31'd0, busy},      32'd0);
        chk({tag, ".pass"},     {31'd0, pass},      {31'd0, r.pass});
        chk({tag, ".errCnt"},   {24'd0, errCnt},    {24'd0, r.errCnt});
        chk({tag, ".failCode"}, {29'd0, failCode},  {29'd0, r.failCode});
        chk({tag, ".failIdx"},  {26'd0, failIndex}, {26'd0, r.failIndex});
        chk({tag, ".lastRx"},   {24'd0, lastRx},    {24'd0, r.lastRx});
        chk({tag, ".txLeft"},   txExp.size(),       32'd0);
        txExp.delete();
        start = 1'b0;
        step();
        step();
        chk({tag, ".actRel"},   {31'd0, startActivation}, 32'd0);
        chk({tag, ".doneClr"},  {31'd0, done},            32'd0);
    endtask

    initial begin
        int el;
        int n;
        nReset        = 1'b0;
        scriptWe      = 1'b0;
        scriptAddr    = '0;
        scriptData    = '0;
        start         = 1'b0;
        stopOnError   = 1'b0;
        timeoutCycles = '0;
        step();
        step();
        chkReset("rst");
        nReset = 1'b1;
        step();

        // Nominal TPDU; a write attempted while busy must be dropped
        loadBase();
        pushTx(6);
        runCheck("pass", mkRes(1'b1, 8'd0, FcNone, 6'd0, 8'h00), 400, 1'b1, el);

        // Mismatch at entry 7, continue
        load(7, OpExpect, 8'h91);
        pushTx(6);
        runCheck("mmCont", mkRes(1'b0, 8'd1, FcMismatch, 6'd7, 8'h00), 400, 1'b0, el);

        // Mismatch at entry 7, stop: only two bytes ever consumed
        stopOnError = 1'b1;
        csCount = 0;
        pushTx(6);
        runCheck("mmStop", mkRes(1'b0, 8'd1, FcMismatch, 6'd7, 8'h90), 400, 1'b0, el);
        chk("mmStop.csPulses", csCount, 32'd2);
        stopOnError = 1'b0;

        // No card response: timeout
        load(0, OpExpect, 8'h3B);
        load(1, OpEnd,    8'h00);
        timeoutCycles = 24'd5000;
        runCheck("tmo", mkRes(1'b0, 8'd0, FcTimeout, 6'd0, 8'h00), 6000, 1'b0, el);
        chk("tmo.window", 32'(el >= 5000 && el <= 5008), 32'd1);
        timeoutCycles = '0;

        // Frame error on first receive is fatal even with stopOnError=0
        loadBase();
        forceFrame = 1'b1;
        pushTx(5);
        runCheck("frame", mkRes(1'b0, 8'd1, FcFrame, 6'd5, 8'h0C), 400, 1'b0, el);
        forceFrame = 1'b0;

        // Reset pulse during a SEND, then rerun from the retained RAM
        pushTx(6);
        start = 1'b1;
        n = 0;
        while (nWeDataIn !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        chk("midRst.weSeen", {31'd0, nWeDataIn}, 32'd0);
        nReset = 1'b0;
        step();
        chkReset("midRst");
        nReset = 1'b1;
        start  = 1'b0;
        txExp.delete();
        step();
        step();
        pushTx(6);
        runCheck("rerun", mkRes(1'b1, 8'd0, FcNone, 6'd0, 8'h00), 400, 1'b0, el);

        // SKIP accepts any byte
        load(5, OpSkip, 8'hEE);
        pushTx(6);
        runCheck("skip", mkRes(1'b1, 8'd0, FcNone, 6'd0, 8'h00), 400, 1'b0, el);

        // Full script of SENDs with no END
        for (int i = 0; i < DEPTH; i++) load(i, OpSend, 8'(i));
        pushTx(DEPTH);
        runCheck("wrap", mkRes(1'b0, 8'd0, FcWrap, 6'd63, 8'h00), 2000, 1'b0, el);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
